// File: rtl/fwd_def.sv
// Shared definitions for the operand forwarding pipeline: register-zero
// constant, forwarding source encoding and the writeback control encoding.
package fwd_def;

  localparam int REG_ZERO = 0;

  typedef enum logic [1:0] {
    SRC_RF  = 2'd0,
    SRC_EX  = 2'd1,
    SRC_STG = 2'd2
  } src_sel_e;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'd0,
    WB_SEL_MEM = 2'd1,
    WB_SEL_PC4 = 2'd2
  } wb_sel_e;

endpackage

// File: rtl/fwd_match_sel.sv
// Priority search for one ID operand over the EX instruction and the tracked
// result stages; the youngest matching producer wins.
module fwd_match_sel
  import fwd_def::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3
) (
  input  logic [REG_AW-1:0]       reg_addr_i,
  input  logic [DATA_W-1:0]       rf_data_i,
  input  logic                    iss_valid_i,
  input  logic                    iss_we_i,
  input  logic [REG_AW-1:0]       iss_rd_i,
  input  logic                    iss_is_load_i,
  input  logic [DATA_W-1:0]       ex_result_i,
  input  logic [DATA_W-1:0]       ld_data_i,
  input  logic [DEPTH-1:0]        stg_v_i,
  input  logic [DEPTH-1:0]        stg_we_i,
  input  logic                    stg0_ld_i,
  input  logic [DEPTH*REG_AW-1:0] stg_rd_i,
  input  logic [DEPTH*DATA_W-1:0] stg_data_i,
  output logic [DATA_W-1:0]       sel_data_o,
  output logic                    not_ready_o,
  output src_sel_e                src_o
);

  // Scan oldest to youngest so each later hit overrides an older one.
  always_comb begin
    sel_data_o  = rf_data_i;
    not_ready_o = 1'b0;
    src_o       = SRC_RF;
    if (reg_addr_i != REG_AW'(REG_ZERO)) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (stg_v_i[k] && stg_we_i[k] && (stg_rd_i[k*REG_AW +: REG_AW] == reg_addr_i)) begin
          sel_data_o = (k == 0 && stg0_ld_i) ? ld_data_i : stg_data_i[k*DATA_W +: DATA_W];
          src_o      = SRC_STG;
        end
      end
      if (iss_valid_i && iss_we_i && (iss_rd_i == reg_addr_i)) begin
        sel_data_o  = ex_result_i;
        not_ready_o = iss_is_load_i;
        src_o       = SRC_EX;
      end
    end
  end

endmodule

// File: rtl/operand_fwd_pipe.sv
// Writeback/forwarding stage: DEPTH-entry result pipeline, operand bypass and
// load-use stall. Define FWD_STATS_EN to add fwd_cnt/stall_cnt counters.
module operand_fwd_pipe
  import fwd_def::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  input  logic              iss_valid,
  input  logic              iss_we,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic              iss_is_load,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] fwd_a,
  output logic [DATA_W-1:0] fwd_b,
  output logic              stall,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]       fwd_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  logic [DEPTH-1:0]        v_q, v_d, we_q, we_d;
  logic                    ld0_q, ld0_d;
  logic [REG_AW-1:0]       rd_q   [DEPTH];
  logic [REG_AW-1:0]       rd_d   [DEPTH];
  logic [DATA_W-1:0]       data_q [DEPTH];
  logic [DATA_W-1:0]       data_d [DEPTH];
  logic [DEPTH*REG_AW-1:0] rd_flat;
  logic [DEPTH*DATA_W-1:0] data_flat;

  // Only stage 0 can hold a pending load; stage 1 resolves it with ld_data.
  always_comb begin
    v_d       = {v_q[DEPTH-2:0], iss_valid};
    we_d      = {we_q[DEPTH-2:0], iss_we};
    ld0_d     = iss_is_load;
    rd_d[0]   = iss_rd;
    data_d[0] = ex_result;
    for (int k = 1; k < DEPTH; k++) begin
      rd_d[k]   = rd_q[k-1];
      data_d[k] = data_q[k-1];
    end
    if (ld0_q) data_d[1] = ld_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_q   <= '0;
      we_q  <= '0;
      ld0_q <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k]   <= '0;
        data_q[k] <= '0;
      end
    end else begin
      v_q   <= v_d;
      we_q  <= we_d;
      ld0_q <= ld0_d;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k]   <= rd_d[k];
        data_q[k] <= data_d[k];
      end
    end
  end

  assign wb_we   = v_q[DEPTH-1] & we_q[DEPTH-1] & (rd_q[DEPTH-1] != REG_AW'(REG_ZERO));
  assign wb_addr = rd_q[DEPTH-1];
  assign wb_data = data_q[DEPTH-1];

  logic [REG_AW-1:0] op_reg  [2];
  logic [DATA_W-1:0] op_rf   [2];
  logic [DATA_W-1:0] op_data [2];
  logic              op_nr   [2];
  src_sel_e          op_src  [2];

  assign op_reg[0] = id_rs;
  assign op_reg[1] = id_rt;
  assign op_rf[0]  = rf_rd1;
  assign op_rf[1]  = rf_rd2;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign rd_flat[gi*REG_AW +: REG_AW]   = rd_q[gi];
      assign data_flat[gi*DATA_W +: DATA_W] = data_q[gi];
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_op
      fwd_match_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH)) u_sel (
        .reg_addr_i    (op_reg[gi]),
        .rf_data_i     (op_rf[gi]),
        .iss_valid_i   (iss_valid),
        .iss_we_i      (iss_we),
        .iss_rd_i      (iss_rd),
        .iss_is_load_i (iss_is_load),
        .ex_result_i   (ex_result),
        .ld_data_i     (ld_data),
        .stg_v_i       (v_q),
        .stg_we_i      (we_q),
        .stg0_ld_i     (ld0_q),
        .stg_rd_i      (rd_flat),
        .stg_data_i    (data_flat),
        .sel_data_o    (op_data[gi]),
        .not_ready_o   (op_nr[gi]),
        .src_o         (op_src[gi])
      );
    end
  endgenerate

  assign fwd_a = op_data[0];
  assign fwd_b = op_data[1];
  assign stall = ((op_src[0] == SRC_EX) & op_nr[0]) | ((op_src[1] == SRC_EX) & op_nr[1]);

`ifdef FWD_STATS_EN
  logic [31:0] fwd_cnt_q, stall_cnt_q;
  logic [1:0]  fwd_inc;
  logic [32:0] fwd_sum;

  assign fwd_inc = stall ? 2'd0 :
                   ({1'b0, op_src[0] != SRC_RF} + {1'b0, op_src[1] != SRC_RF});
  assign fwd_sum = {1'b0, fwd_cnt_q} + 33'(fwd_inc);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      fwd_cnt_q <= fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fwd_cnt   = fwd_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_operand_fwd_pipe.sv
// Self-checking bench for operand_fwd_pipe: directed vector table, reset
// corner cases and randomized traffic against a queue-based reference model.
module tb_operand_fwd_pipe;

  localparam int DEPTH = 3;

  logic        clk, rstn;
  logic [4:0]  id_rs, id_rt, iss_rd;
  logic [31:0] rf_rd1, rf_rd2, ex_result, ld_data;
  logic        iss_valid, iss_we, iss_is_load;
  logic [31:0] fwd_a, fwd_b, wb_data;
  logic        stall, wb_we;
  logic [4:0]  wb_addr;
`ifdef FWD_STATS_EN
  logic [31:0] fwd_cnt, stall_cnt;
  longint      mc_fwd, mc_stall;
`endif

  int checks = 0;
  int errors = 0;

  operand_fwd_pipe #(.DATA_W(32), .REG_AW(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .id_rs(id_rs), .id_rt(id_rt),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .iss_valid(iss_valid), .iss_we(iss_we),
    .iss_rd(iss_rd), .iss_is_load(iss_is_load), .ex_result(ex_result), .ld_data(ld_data),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data(wb_data)
`ifdef FWD_STATS_EN
    , .fwd_cnt(fwd_cnt), .stall_cnt(stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: pipe[0] is the youngest retired-from-EX instruction.
  typedef struct {
    bit          v, we, ld;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;
  ent_t pipe[$];

  function automatic void model_reset();
    ent_t e;
    e = '{v: 0, we: 0, ld: 0, rd: '0, data: '0};
    pipe.delete();
    for (int i = 0; i < DEPTH; i++) pipe.push_back(e);
`ifdef FWD_STATS_EN
    mc_fwd = 0;
    mc_stall = 0;
`endif
  endfunction

  function automatic void model_fwd(input logic [4:0] r, input logic [31:0] rf,
                                    output logic [31:0] d, output bit nr, output bit fw);
    d = rf; nr = 0; fw = 0;
    if (r == 5'd0) return;
    if (iss_valid && iss_we && iss_rd == r) begin
      d = ex_result; nr = iss_is_load; fw = 1;
      return;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (pipe[i].v && pipe[i].we && pipe[i].rd == r) begin
        d = pipe[i].ld ? ld_data : pipe[i].data;
        fw = 1;
        return;
      end
    end
  endfunction

  function automatic void model_edge();
    ent_t e;
`ifdef FWD_STATS_EN
    logic [31:0] d;
    bit nra, nrb, fwa, fwb;
    model_fwd(id_rs, rf_rd1, d, nra, fwa);
    model_fwd(id_rt, rf_rd2, d, nrb, fwb);
    if (nra || nrb) mc_stall++;
    else mc_fwd += int'(fwa) + int'(fwb);
`endif
    if (pipe[0].ld) begin
      pipe[0].data = ld_data;
      pipe[0].ld = 0;
    end
    e = '{v: iss_valid, we: iss_we, ld: iss_is_load, rd: iss_rd, data: ex_result};
    pipe.push_front(e);
    void'(pipe.pop_back());
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (rstn) model_edge();
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    logic [31:0] ea, eb;
    bit nra, nrb, fwa, fwb, ewe;
    model_fwd(id_rs, rf_rd1, ea, nra, fwa);
    model_fwd(id_rt, rf_rd2, eb, nrb, fwb);
    ewe = pipe[DEPTH-1].v && pipe[DEPTH-1].we && pipe[DEPTH-1].rd != 5'd0;
    chk({tag, " fwd_a"}, fwd_a, ea);
    chk({tag, " fwd_b"}, fwd_b, eb);
    chk({tag, " stall"}, 32'(stall), 32'(nra || nrb));
    chk({tag, " wb_we"}, 32'(wb_we), 32'(ewe));
    if (ewe) begin
      chk({tag, " wb_addr"}, 32'(wb_addr), 32'(pipe[DEPTH-1].rd));
      chk({tag, " wb_data"}, wb_data, pipe[DEPTH-1].data);
    end
    $display("%s rs=%0d rt=%0d a=%h b=%h stall=%b wb=%b/%0d/%h",
             tag, id_rs, id_rt, fwd_a, fwd_b, stall, wb_we, wb_addr, wb_data);
  endtask

  task automatic idle_inputs();
    iss_valid = 0; iss_we = 0; iss_is_load = 0; iss_rd = '0;
    ex_result = '0; ld_data = '0;
  endtask

  typedef struct {
    logic [4:0]  rs, rt;
    logic        iv, iw, il;
    logic [4:0]  ird;
    logic [31:0] ex, ld;
    logic [31:0] ea, eb;
    logic        es, ewe;
    logic [4:0]  ewa;
    logic [31:0] ewd;
  } vec_t;
  vec_t vec[15];

  initial begin
    // rs rt iv iw il ird ex ld | fwd_a fwd_b stall wb_we wb_addr wb_data
    vec[0]  = '{8, 3, 1, 1, 0, 8, 32'hA5,   0,        32'hA5,   32'h200,  0, 0, 0, 0};
    vec[1]  = '{8, 3, 0, 0, 0, 0, 0,        0,        32'hA5,   32'h200,  0, 0, 0, 0};
    vec[2]  = '{8, 3, 0, 0, 0, 0, 0,        0,        32'hA5,   32'h200,  0, 0, 0, 0};
    vec[3]  = '{8, 3, 0, 0, 0, 0, 0,        0,        32'hA5,   32'h200,  0, 1, 8, 32'hA5};
    vec[4]  = '{8, 9, 1, 1, 1, 9, 32'h5555, 0,        32'h100,  32'h5555, 1, 0, 0, 0};
    vec[5]  = '{8, 9, 0, 0, 0, 0, 0,        32'hDEAD, 32'h100,  32'hDEAD, 0, 0, 0, 0};
    vec[6]  = '{4, 9, 1, 1, 0, 4, 32'h1,    32'hBEEF, 32'h1,    32'hDEAD, 0, 0, 0, 0};
    vec[7]  = '{4, 9, 1, 1, 0, 4, 32'h2,    0,        32'h2,    32'hDEAD, 0, 1, 9, 32'hDEAD};
    vec[8]  = '{4, 0, 0, 0, 0, 0, 0,        0,        32'h2,    32'h200,  0, 0, 0, 0};
    vec[9]  = '{0, 4, 1, 1, 0, 0, 32'h7,    0,        32'h100,  32'h2,    0, 1, 4, 32'h1};
    vec[10] = '{0, 3, 0, 0, 0, 0, 0,        0,        32'h100,  32'h200,  0, 1, 4, 32'h2};
    vec[11] = '{0, 3, 0, 0, 0, 0, 0,        0,        32'h100,  32'h200,  0, 0, 0, 0};
    vec[12] = '{5, 5, 1, 1, 1, 5, 32'h3333, 0,        32'h3333, 32'h3333, 1, 0, 0, 0};
    vec[13] = '{5, 5, 0, 0, 0, 0, 0,        32'h1234, 32'h1234, 32'h1234, 0, 0, 0, 0};
    vec[14] = '{5, 0, 0, 0, 0, 0, 0,        32'h9999, 32'h1234, 32'h200,  0, 0, 0, 0};

    // Reset state
    rstn = 1'b0;
    idle_inputs();
    id_rs = 5; id_rt = 6; rf_rd1 = 32'h11; rf_rd2 = 32'h22;
    model_reset();
    @(negedge clk);
    #1;
    chk("reset fwd_a", fwd_a, 32'h11);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset wb_we", 32'(wb_we), 32'd0);
    chk("reset wb_addr", 32'(wb_addr), 32'd0);
    chk("reset wb_data", wb_data, 32'd0);
    $display("reset a=%h stall=%b wb_we=%b", fwd_a, stall, wb_we);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      #1 check_model("idle");
      advance();
    end

    // Directed vector table
    rf_rd1 = 32'h100; rf_rd2 = 32'h200;
    foreach (vec[i]) begin
      id_rs = vec[i].rs; id_rt = vec[i].rt;
      iss_valid = vec[i].iv; iss_we = vec[i].iw; iss_is_load = vec[i].il;
      iss_rd = vec[i].ird; ex_result = vec[i].ex; ld_data = vec[i].ld;
      #1;
      chk($sformatf("vec%0d fwd_a", i), fwd_a, vec[i].ea);
      chk($sformatf("vec%0d fwd_b", i), fwd_b, vec[i].eb);
      chk($sformatf("vec%0d stall", i), 32'(stall), 32'(vec[i].es));
      chk($sformatf("vec%0d wb_we", i), 32'(wb_we), 32'(vec[i].ewe));
      if (vec[i].ewe) begin
        chk($sformatf("vec%0d wb_addr", i), 32'(wb_addr), 32'(vec[i].ewa));
        chk($sformatf("vec%0d wb_data", i), wb_data, vec[i].ewd);
      end
      $display("vec%0d a=%h b=%h stall=%b wb=%b/%0d/%h", i, fwd_a, fwd_b, stall, wb_we, wb_addr, wb_data);
      advance();
    end
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) advance();

    // Reset asserted mid-flight between clock edges
    for (int i = 1; i <= 3; i++) begin
      iss_valid = 1; iss_we = 1; iss_rd = 5'(i); ex_result = 32'hC0 + 32'(i);
      advance();
    end
    idle_inputs();
    id_rs = 2; id_rt = 3;
    #1 check_model("preflush");
    chk("preflush wb_we", 32'(wb_we), 32'd1);
    #2 rstn = 1'b0;
    model_reset();
    #1;
    chk("flush wb_we", 32'(wb_we), 32'd0);
    chk("flush fwd_a", fwd_a, rf_rd1);
    chk("flush fwd_b", fwd_b, rf_rd2);
    chk("flush stall", 32'(stall), 32'd0);
    $display("flush a=%h b=%h wb_we=%b", fwd_a, fwd_b, wb_we);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      #1 check_model("postflush");
      advance();
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      id_rs = 5'($urandom_range(0, 7));
      id_rt = 5'($urandom_range(0, 7));
      rf_rd1 = $urandom; rf_rd2 = $urandom;
      iss_valid = ($urandom_range(0, 3) != 0);
      iss_we = ($urandom_range(0, 4) != 0);
      iss_is_load = iss_we && ($urandom_range(0, 3) == 0);
      iss_rd = 5'($urandom_range(0, 7));
      ex_result = $urandom; ld_data = $urandom;
      #1 check_model($sformatf("rnd%0d", i));
      advance();
    end
`ifdef FWD_STATS_EN
    chk("fwd_cnt", fwd_cnt, 32'(mc_fwd));
    chk("stall_cnt", stall_cnt, 32'(mc_stall));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
